// File: rtl/sprite_bank_arbiter_if.sv
// Bundle of renderer, loader and BRAM-side signals for the sprite bank arbiter.
// The slave modport is the arbiter; the master modport is everything around it.
interface sprite_bank_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [9:0]        vcount_in;
  logic              rd_req_in;
  logic [ADDR_W-1:0] rd_addr_in;
  logic [DATA_W-1:0] rd_data_out;
  logic              rd_valid_out;
  logic              wr_valid_in;
  logic [ADDR_W-1:0] wr_addr_in;
  logic [DATA_W-1:0] wr_data_in;
  logic              wr_last_in;
  logic              wr_ready_out;
  logic [ADDR_W:0]   bram_addr_out;
  logic [DATA_W-1:0] bram_din_out;
  logic              bram_we_out;
  logic              bram_en_out;
  logic [DATA_W-1:0] bram_dout_in;
  logic              front_bank_out;
  logic              swap_pending_out;
  logic [15:0]       wr_stall_count_out;

  modport slave (
    input  vcount_in, rd_req_in, rd_addr_in, wr_valid_in, wr_addr_in, wr_data_in,
           wr_last_in, bram_dout_in,
    output rd_data_out, rd_valid_out, wr_ready_out, bram_addr_out, bram_din_out,
           bram_we_out, bram_en_out, front_bank_out, swap_pending_out, wr_stall_count_out
  );

  modport master (
    output vcount_in, rd_req_in, rd_addr_in, wr_valid_in, wr_addr_in, wr_data_in,
           wr_last_in, bram_dout_in,
    input  rd_data_out, rd_valid_out, wr_ready_out, bram_addr_out, bram_din_out,
           bram_we_out, bram_en_out, front_bank_out, swap_pending_out, wr_stall_count_out
  );
endinterface

// File: rtl/sprite_bank_arbiter.sv
// Double-buffered sprite BRAM arbiter: reads hit the front bank with fixed priority,
// loader writes fill the back bank, banks swap at the start of vertical blanking.
//
// state     | meaning
// FILL      | loader may write the back bank
// WAIT_SWAP | full frame loaded, writes blocked until the next blank event
module sprite_bank_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int BRAM_LATENCY = 2,
  parameter int V_ACTIVE     = 768
) (
  input  logic                    pixel_clk_in,
  input  logic                    rst_n_in,
  sprite_bank_arbiter_if.slave    bus
);

  typedef enum logic {FILL = 1'b0, WAIT_SWAP = 1'b1} state_t;

  state_t              state;
  logic                front_bank;
  logic                swap_pending;
  logic [9:0]          vcount_q;
  logic                vcount_q_vld;
  logic [15:0]         stall_cnt;
  logic                rd_issue;
  logic [BRAM_LATENCY-1:0] rd_pipe;
  logic                rd_valid_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic [ADDR_W:0]     bram_addr_q;
  logic [DATA_W-1:0]   bram_din_q;
  logic                bram_we_q;
  logic                bram_en_q;

  logic wr_ready;
  logic wr_accept;
  logic blank_evt;
  logic stall_evt;

  assign wr_ready  = rst_n_in & ~bus.rd_req_in & (state == FILL);
  assign wr_accept = bus.wr_valid_in & wr_ready;
  assign stall_evt = bus.wr_valid_in & ~wr_ready;
  // vcount_q_vld makes the first post-reset cycle count as an edge into blanking
  assign blank_evt = (bus.vcount_in == 10'(V_ACTIVE)) &&
                     (!vcount_q_vld || (vcount_q != 10'(V_ACTIVE)));

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= FILL;
      front_bank   <= 1'b0;
      swap_pending <= 1'b0;
      vcount_q     <= '0;
      vcount_q_vld <= 1'b0;
      stall_cnt    <= '0;
      rd_issue     <= 1'b0;
      rd_pipe      <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      bram_addr_q  <= '0;
      bram_din_q   <= '0;
      bram_we_q    <= 1'b0;
      bram_en_q    <= 1'b0;
    end else begin
      vcount_q     <= bus.vcount_in;
      vcount_q_vld <= 1'b1;

      rd_issue   <= bus.rd_req_in;
      rd_pipe[0] <= rd_issue;
      for (int i = 1; i < BRAM_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
      rd_valid_q <= rd_pipe[BRAM_LATENCY-1];
      if (rd_pipe[BRAM_LATENCY-1]) rd_data_q <= bus.bram_dout_in;

      // Bank bit is taken from the pre-swap front_bank, so a read sampled on the
      // swap edge still addresses the old front bank.
      if (bus.rd_req_in) begin
        bram_en_q   <= 1'b1;
        bram_we_q   <= 1'b0;
        bram_addr_q <= {front_bank, bus.rd_addr_in};
      end else if (wr_accept) begin
        bram_en_q   <= 1'b1;
        bram_we_q   <= 1'b1;
        bram_addr_q <= {~front_bank, bus.wr_addr_in};
        bram_din_q  <= bus.wr_data_in;
      end else begin
        bram_en_q <= 1'b0;
        bram_we_q <= 1'b0;
      end

      case (state)
        FILL: begin
          if (wr_accept && bus.wr_last_in) begin
            state        <= WAIT_SWAP;
            swap_pending <= 1'b1;
          end
        end
        WAIT_SWAP: begin
          if (blank_evt) begin
            state        <= FILL;
            swap_pending <= 1'b0;
            front_bank   <= ~front_bank;
          end
        end
        default: begin
          state        <= FILL;
          swap_pending <= 1'b0;
        end
      endcase

      if (blank_evt && (state == WAIT_SWAP)) stall_cnt <= '0;
      else if (stall_evt && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign bus.wr_ready_out       = wr_ready;
  assign bus.rd_data_out        = rd_data_q;
  assign bus.rd_valid_out       = rd_valid_q;
  assign bus.bram_addr_out      = bram_addr_q;
  assign bus.bram_din_out       = bram_din_q;
  assign bus.bram_we_out        = bram_we_q;
  assign bus.bram_en_out        = bram_en_q;
  assign bus.front_bank_out     = front_bank;
  assign bus.swap_pending_out   = swap_pending;
  assign bus.wr_stall_count_out = stall_cnt;

endmodule

// File: tb/tb_sprite_bank_arbiter.sv
// Scoreboard bench for sprite_bank_arbiter: directed reads/writes/swaps with a
// latency-2 BRAM model; read responses are checked by a separate monitor.
module tb_sprite_bank_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sprite_bank_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  sprite_bank_arbiter #(.ADDR_W(16), .DATA_W(8), .BRAM_LATENCY(2), .V_ACTIVE(768)) dut (
    .pixel_clk_in (clk),
    .rst_n_in     (rst_n),
    .bus          (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [7:0] pat(input logic bank, input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ (bank ? 8'h5A : 8'h00);
  endfunction

  // BRAM model: contents preset to pat(), 2-cycle read latency
  logic [7:0] mem [0:131071];
  logic       mem_init = 1'b0;
  logic [7:0] d1 = 8'h00;
  logic [7:0] dout = 8'h00;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 131072; i++) mem[i] <= pat(i[16], i[15:0]);
      mem_init <= 1'b1;
    end else if (bus.bram_en_out) begin
      if (bus.bram_we_out) mem[bus.bram_addr_out] <= bus.bram_din_out;
      else d1 <= mem[bus.bram_addr_out];
    end
    dout <= d1;
  end
  assign bus.bram_dout_in = dout;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (bus.rd_valid_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: valid at cycle %0d data %0h, none expected", cyc_cnt, bus.rd_data_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.cyc != cyc_cnt || e.data !== bus.rd_data_out) begin
          errors++;
          $display("FAIL rd_data: cycle %0d data %0h, expected cycle %0d data %0h",
                   cyc_cnt, bus.rd_data_out, e.cyc, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [15:0] a, input logic bank, input logic [7:0] d);
    bus.rd_req_in  = 1'b1;
    bus.rd_addr_in = a;
    step();
    chk("rd_bram_addr", 32'(bus.bram_addr_out), 32'({bank, a}));
    exp_q.push_back('{cyc: cyc_cnt + 3, data: d});
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input logic last,
                          input logic bank);
    bus.wr_valid_in = 1'b1;
    bus.wr_addr_in  = a;
    bus.wr_data_in  = d;
    bus.wr_last_in  = last;
    #1;
    chk("wr_ready", 32'(bus.wr_ready_out), 32'd1);
    step();
    chk("wr_bram_addr", 32'(bus.bram_addr_out), 32'({bank, a}));
    chk("wr_bram_we", 32'(bus.bram_we_out), 32'd1);
    chk("wr_bram_din", 32'(bus.bram_din_out), 32'(d));
    bus.wr_valid_in = 1'b0;
    bus.wr_last_in  = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_valid"}, 32'(bus.rd_valid_out), 32'd0);
    chk({tag, "_rd_data"}, 32'(bus.rd_data_out), 32'd0);
    chk({tag, "_bram_en"}, 32'(bus.bram_en_out), 32'd0);
    chk({tag, "_bram_addr"}, 32'(bus.bram_addr_out), 32'd0);
    chk({tag, "_front"}, 32'(bus.front_bank_out), 32'd0);
    chk({tag, "_pending"}, 32'(bus.swap_pending_out), 32'd0);
    chk({tag, "_stall"}, 32'(bus.wr_stall_count_out), 32'd0);
    chk({tag, "_wr_ready"}, 32'(bus.wr_ready_out), 32'd0);
  endtask

  initial begin
    logic ready_seen;
    rst_n           = 1'b0;
    bus.vcount_in   = 10'd0;
    bus.rd_req_in   = 1'b0;
    bus.rd_addr_in  = '0;
    bus.wr_valid_in = 1'b0;
    bus.wr_addr_in  = '0;
    bus.wr_data_in  = '0;
    bus.wr_last_in  = 1'b0;
    #1;
    chk_all_zero("reset");
    step();
    step();
    rst_n = 1'b1;
    step();

    // Back-to-back reads of bank 0, addresses 0..15
    for (int i = 0; i < 16; i++) do_read(16'(i), 1'b0, pat(1'b0, 16'(i)));
    bus.rd_req_in = 1'b0;
    step();

    // Loader held valid while reads take every other cycle
    for (int i = 0; i < 8; i++) begin
      bus.rd_req_in   = i[0];
      bus.rd_addr_in  = 16'h0030 + 16'(i);
      bus.wr_valid_in = 1'b1;
      bus.wr_addr_in  = 16'h0200 + 16'(i);
      bus.wr_data_in  = 8'hA0 + 8'(i);
      #1;
      chk("alt_wr_ready", 32'(bus.wr_ready_out), 32'(!i[0]));
      step();
      if (i[0]) begin
        chk("alt_rd_addr", 32'(bus.bram_addr_out), 32'({1'b0, 16'h0030 + 16'(i)}));
        exp_q.push_back('{cyc: cyc_cnt + 3, data: pat(1'b0, 16'h0030 + 16'(i))});
      end else begin
        chk("alt_wr_addr", 32'(bus.bram_addr_out), 32'({1'b1, 16'h0200 + 16'(i)}));
        chk("alt_wr_we", 32'(bus.bram_we_out), 32'd1);
      end
    end
    bus.rd_req_in   = 1'b0;
    bus.wr_valid_in = 1'b0;
    chk("alt_stall", 32'(bus.wr_stall_count_out), 32'd4);

    // Load a 4-word frame, then swap at the 767->768 transition
    for (int i = 0; i < 4; i++) do_write(16'h0100 + 16'(i), 8'h50 + 8'(i), (i == 3), 1'b1);
    chk("load_pending", 32'(bus.swap_pending_out), 32'd1);
    bus.vcount_in = 10'd767;
    step();
    step();
    chk("pre_swap_pending", 32'(bus.swap_pending_out), 32'd1);
    chk("pre_swap_front", 32'(bus.front_bank_out), 32'd0);
    chk("pre_swap_stall", 32'(bus.wr_stall_count_out), 32'd4);
    bus.vcount_in = 10'd768;
    do_read(16'h0100, 1'b0, pat(1'b0, 16'h0100));
    chk("swap_front", 32'(bus.front_bank_out), 32'd1);
    chk("swap_pending", 32'(bus.swap_pending_out), 32'd0);
    chk("swap_stall", 32'(bus.wr_stall_count_out), 32'd0);
    for (int i = 0; i < 4; i++) do_read(16'h0100 + 16'(i), 1'b1, 8'h50 + 8'(i));
    do_read(16'h0202, 1'b1, 8'hA2);
    do_read(16'h0201, 1'b1, 8'h59);
    bus.rd_req_in = 1'b0;
    step();

    // Blank in FILL does nothing; wr_last on the blank cycle defers the swap
    bus.vcount_in = 10'd0;
    step();
    bus.vcount_in = 10'd768;
    step();
    step();
    chk("fill_blank_front", 32'(bus.front_bank_out), 32'd1);
    bus.vcount_in = 10'd0;
    step();
    bus.vcount_in = 10'd768;
    do_write(16'h0300, 8'h77, 1'b1, 1'b0);
    chk("coinc_pending", 32'(bus.swap_pending_out), 32'd1);
    chk("coinc_front", 32'(bus.front_bank_out), 32'd1);
    bus.vcount_in = 10'd0;
    step();
    step();
    chk("coinc_hold_front", 32'(bus.front_bank_out), 32'd1);
    bus.vcount_in = 10'd767;
    step();
    bus.vcount_in = 10'd768;
    step();
    chk("next_frame_front", 32'(bus.front_bank_out), 32'd0);
    chk("next_frame_pending", 32'(bus.swap_pending_out), 32'd0);

    // Long stall in WAIT_SWAP saturates the counter; swap clears it
    bus.vcount_in = 10'd0;
    step();
    do_write(16'h0010, 8'h11, 1'b1, 1'b1);
    bus.wr_valid_in = 1'b1;
    ready_seen = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      step();
      if (bus.wr_ready_out) ready_seen = 1'b1;
    end
    chk("sat_ready_low", 32'(ready_seen), 32'd0);
    chk("sat_stall", 32'(bus.wr_stall_count_out), 32'hFFFF);
    bus.vcount_in = 10'd767;
    step();
    chk("sat_stall_hold", 32'(bus.wr_stall_count_out), 32'hFFFF);
    bus.vcount_in = 10'd768;
    step();
    chk("sat_swap_stall", 32'(bus.wr_stall_count_out), 32'd0);
    chk("sat_swap_front", 32'(bus.front_bank_out), 32'd1);
    bus.wr_valid_in = 1'b0;
    bus.vcount_in   = 10'd0;
    step();

    // Reset with a pending swap and two reads in flight
    do_write(16'h0020, 8'h22, 1'b1, 1'b0);
    bus.rd_req_in  = 1'b1;
    bus.rd_addr_in = 16'h0040;
    step();
    bus.rd_addr_in = 16'h0041;
    step();
    bus.rd_req_in = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step();
    do_read(16'h0007, 1'b0, pat(1'b0, 16'h0007));
    bus.rd_req_in = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
